// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and status bit positions for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD,
    S_WR,
    S_STAT,
    S_WAIT_CS,
    S_IGNORE
  } state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Brings SCK/CSbar/DI into the clk domain and derives single-cycle edge pulses.
// DI goes through the same depth as SCK so it lines up with sck_rise.
module spi_slave_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic csbar,
  input  logic di,
  output logic cs_s,
  output logic di_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [2:0] sck_p;
  logic [2:0] cs_p;
  logic [1:0] di_p;

  // two sync stages plus one history stage for edge detection; CS idles deasserted
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_p <= '0;
      cs_p  <= '1;
      di_p  <= '0;
    end else begin
      sck_p <= {sck_p[1:0], sck};
      cs_p  <= {cs_p[1:0], csbar};
      di_p  <= {di_p[0], di};
    end
  end

  assign cs_s     = cs_p[1];
  assign di_s     = di_p[1];
  assign sck_rise =  sck_p[1] & ~sck_p[2];
  assign sck_fall = ~sck_p[1] &  sck_p[2];
  assign cs_rise  =  cs_p[1]  & ~cs_p[2];
  assign cs_fall  = ~cs_p[1]  &  cs_p[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: WREN/WRDI/RDSR/READ/PP/SE over an
// on-chip byte array with WEL/WIP semantics, program latency and sector erase.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int MEM_DEPTH   = 4096,
  parameter int PAGE_SIZE   = 256,
  parameter int SECTOR_SIZE = 1024,
  parameter int PROG_LAT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         SCK,
  input  logic                         CSbar,
  input  logic                         DI,
  output logic                         DO,
  output logic [7:0]                   status,
  output logic [15:0]                  cmd_count,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [7:0]                   dbg_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(PAGE_SIZE);
  localparam int SW = $clog2(SECTOR_SIZE);
  localparam int LW = $clog2(PROG_LAT + 1);

  logic cs_s, di_s, sck_rise, sck_fall, cs_rise, cs_fall;

  spi_slave_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (SCK),
    .csbar    (CSbar),
    .di       (DI),
    .cs_s     (cs_s),
    .di_s     (di_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  state_t          state, state_n;
  logic [7:0]      sr, op, tx;
  logic [2:0]      bit_cnt;
  logic [5:0]      frame_bits;   // saturating bit count for the current frame
  logic [AW-1:0]   addr_sr, a, rd_addr;
  logic            do_r, ld_pend, pp_any;
  logic            wel, wip, lat_on, ers_on;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   ers_cnt;
  logic [AW-SW-1:0] ers_hi;
  logic [7:0]      rd_q;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [7:0]      mem_wd;
  logic [7:0]      status_w;

  // powers up erased; reset deliberately leaves the contents alone
  logic [7:0] mem [MEM_DEPTH] = '{default: 8'hFF};

  logic [7:0]    byte_in;
  logic [AW-1:0] addr_in;
  logic          byte_done, addr_done, pp_we;

  assign byte_in   = {sr[6:0], di_s};
  assign addr_in   = {addr_sr[AW-2:0], di_s};
  assign byte_done = sck_rise & ~cs_s & (bit_cnt == 3'd7);
  assign addr_done = byte_done & (state == S_ADDR) & (frame_bits == 6'd31);
  assign pp_we     = byte_done & (state == S_WR);

  // status byte assembled from the WEL/WIP flags
  always_comb begin
    status_w         = '0;
    status_w[ST_WEL] = wel;
    status_w[ST_WIP] = wip;
  end

  assign status = status_w;
  assign DO     = do_r;

  // command FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // command FSM next state; CS high forces IDLE from anywhere
  always_comb begin
    state_n = state;
    if (cs_s) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (cs_fall) state_n = S_CMD;
        S_CMD: if (byte_done) begin
          if (byte_in == OP_RDSR) state_n = S_STAT;
          else if (wip)           state_n = S_IGNORE;
          else begin
            case (byte_in)
              OP_WREN, OP_WRDI: state_n = S_WAIT_CS;
              OP_READ:          state_n = S_ADDR;
              OP_PP, OP_SE:     state_n = wel ? S_ADDR : S_IGNORE;
              default:          state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (addr_done) begin
          case (op)
            OP_READ: state_n = S_RD;
            OP_PP:   state_n = S_WR;
            default: state_n = S_WAIT_CS;
          endcase
        end
        default: ;
      endcase
    end
  end

  // read-port address: prefetch the next byte the moment a boundary is reached
  always_comb begin
    rd_addr = a;
    if (addr_done)                      rd_addr = addr_in;
    else if (byte_done && state == S_RD) rd_addr = a + AW'(1);
  end

  // serial shift-in/shift-out, address tracking and page-program bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      op         <= '0;
      tx         <= '0;
      bit_cnt    <= '0;
      frame_bits <= '0;
      addr_sr    <= '0;
      a          <= '0;
      do_r       <= 1'b0;
      ld_pend    <= 1'b0;
      pp_any     <= 1'b0;
    end else begin
      ld_pend <= 1'b0;
      if (cs_s) begin
        bit_cnt    <= '0;
        frame_bits <= '0;
        do_r       <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          sr      <= byte_in;
          if (frame_bits != 6'h3F) frame_bits <= frame_bits + 6'd1;
          if (state == S_ADDR) addr_sr <= addr_in;
        end
        if (byte_done && state == S_CMD) begin
          op     <= byte_in;
          pp_any <= 1'b0;
          tx     <= status_w;
        end
        if (byte_done && state == S_STAT) tx <= status_w;
        if (addr_done) begin
          a <= addr_in;
          if (op == OP_READ) ld_pend <= 1'b1;
        end
        if (byte_done && state == S_RD) begin
          a       <= a + AW'(1);
          ld_pend <= 1'b1;
        end
        if (pp_we) begin
          pp_any <= 1'b1;
          a      <= {a[AW-1:PW], a[PW-1:0] + PW'(1)};
        end
        // memory read lands one clk after the boundary, well before the next fall
        if (ld_pend) tx <= rd_q;
        if (sck_fall) begin
          if (state == S_RD || state == S_STAT) begin
            do_r <= tx[7];
            tx   <= {tx[6:0], 1'b0};
          end else begin
            do_r <= 1'b0;
          end
        end
      end
    end
  end

  // WEL/WIP, program latency, erase sweep and completed-command counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wel       <= 1'b0;
      wip       <= 1'b0;
      lat_on    <= 1'b0;
      lat_cnt   <= '0;
      ers_on    <= 1'b0;
      ers_cnt   <= '0;
      ers_hi    <= '0;
      cmd_count <= '0;
    end else begin
      if (lat_on) begin
        if (lat_cnt == '0) begin
          lat_on <= 1'b0;
          wip    <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - LW'(1);
        end
      end
      if (ers_on) begin
        ers_cnt <= ers_cnt + SW'(1);
        if (ers_cnt == '1) begin
          ers_on <= 1'b0;
          wip    <= 1'b0;
        end
      end
      if (cs_rise) begin
        if (frame_bits >= 6'd8) cmd_count <= cmd_count + 16'd1;
        case (state)
          S_WAIT_CS: begin
            case (op)
              OP_WREN: if (frame_bits == 6'd8) wel <= 1'b1;
              OP_WRDI: if (frame_bits == 6'd8) wel <= 1'b0;
              OP_SE: if (frame_bits == 6'd32) begin
                wel     <= 1'b0;
                wip     <= 1'b1;
                ers_on  <= 1'b1;
                ers_cnt <= '0;
                ers_hi  <= a[AW-1:SW];
              end
              default: ;
            endcase
          end
          S_WR: if (pp_any) begin
            wel     <= 1'b0;
            wip     <= 1'b1;
            lat_on  <= 1'b1;
            lat_cnt <= LW'(PROG_LAT - 1);
          end
          default: ;
        endcase
      end
    end
  end

  // single write port shared by erase sweep and page program (never concurrent)
  always_comb begin
    mem_we = (ers_on | pp_we) & ~rst;
    mem_wa = ers_on ? {ers_hi, ers_cnt} : a;
    mem_wd = ers_on ? 8'hFF : (rd_q & byte_in);
  end

  // array write port plus SPI read port; rd_q already holds mem[a] during WR
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    rd_q <= mem[rd_addr];
  end

  // debug read port; a same-cycle write returns the old contents
  always_ff @(posedge clk) begin
    if (rst) dbg_data <= '0;
    else     dbg_data <= mem[dbg_addr];
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI mode-0 master at clk/8, byte-array model,
// expected bytes queued at stimulus time and compared when DO/dbg produce them.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst, SCK, CSbar, DI;
  logic        DO;
  logic [7:0]  status;
  logic [15:0] cmd_count;
  logic [11:0] dbg_addr;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad   = 0;
  int exp_cmds = 0;
  bit m_wel = 1'b0;
  logic [7:0] model_mem [4096];
  logic [7:0] exp_q [$];

  spi_flash_responder dut (
    .clk       (clk),
    .rst       (rst),
    .SCK       (SCK),
    .CSbar     (CSbar),
    .DI        (DI),
    .DO        (DO),
    .status    (status),
    .cmd_count (cmd_count),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [7:0] got);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = {24'h0, exp_q.pop_front()};
    chk(tag, {24'h0, got}, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // master shifts n bits MSB first; DO sampled just before each rising edge
  task automatic spi_bits(input int n, input logic [31:0] txd, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      DI = txd[i];
      tick(4);
      rx[i] = DO;
      SCK = 1'b1;
      tick(4);
      SCK = 1'b0;
    end
    DI = 1'b0;
  endtask

  task automatic cs_lo();
    CSbar = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    tick(4);
    CSbar = 1'b1;
    tick(8);
  endtask

  task automatic cmd1(input logic [7:0] opc);
    logic [31:0] r;
    cs_lo();
    spi_bits(8, {24'h0, opc}, r);
    cs_hi();
    exp_cmds++;
    if (opc == 8'h06) m_wel = 1'b1;
    if (opc == 8'h04) m_wel = 1'b0;
  endtask

  task automatic rdsr(output logic [7:0] st);
    logic [31:0] r;
    cs_lo();
    spi_bits(8, 32'h05, r);
    spi_bits(8, 32'h0, r);
    cs_hi();
    exp_cmds++;
    st = r[7:0];
  endtask

  task automatic rdsr_sb(input string tag);
    logic [7:0] st;
    exp_q.push_back({6'b0, m_wel, 1'b0});
    rdsr(st);
    sb_pop(tag, st);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] st;
    st = 8'hFF;
    for (int k = 0; k < 40 && st[0]; k++) rdsr(st);
    chk(tag, {24'h0, st}, {24'h0, 6'b0, m_wel, 1'b0});
  endtask

  task automatic pp(input logic [23:0] ad, input int n, input logic [15:0] d);
    logic [31:0] r;
    logic [11:0] pa;
    logic [7:0]  b;
    cs_lo();
    spi_bits(8, 32'h02, r);
    spi_bits(24, {8'h0, ad}, r);
    for (int k = 0; k < n; k++) begin
      b = d[15 - 8*k -: 8];
      spi_bits(8, {24'h0, b}, r);
      if (m_wel) begin
        pa = {ad[11:8], ad[7:0] + 8'(k)};
        model_mem[pa] = model_mem[pa] & b;
      end
    end
    cs_hi();
    exp_cmds++;
    m_wel = 1'b0;
  endtask

  task automatic se(input logic [23:0] ad);
    logic [31:0] r;
    cs_lo();
    spi_bits(8, 32'h20, r);
    spi_bits(24, {8'h0, ad}, r);
    cs_hi();
    exp_cmds++;
    m_wel = 1'b0;
  endtask

  task automatic rd(input logic [23:0] ad, input int n);
    logic [31:0] r;
    logic [11:0] ra;
    ra = ad[11:0];
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[ra]);
      ra = ra + 12'd1;
    end
    cs_lo();
    spi_bits(8, 32'h03, r);
    spi_bits(24, {8'h0, ad}, r);
    for (int k = 0; k < n; k++) begin
      spi_bits(8, 32'h0, r);
      sb_pop("read_byte", r[7:0]);
    end
    cs_hi();
    exp_cmds++;
  endtask

  task automatic dbg_chk(input string tag, input logic [11:0] ad);
    exp_q.push_back(model_mem[ad]);
    dbg_addr = ad;
    tick(2);
    sb_pop(tag, dbg_data);
  endtask

  initial begin
    logic [31:0] r;
    int n;
    for (int i = 0; i < 4096; i++) model_mem[i] = 8'hFF;
    rst = 1'b1; SCK = 1'b0; CSbar = 1'b1; DI = 1'b0; dbg_addr = '0;
    tick(3);
    chk("rst_status", {24'h0, status}, 32'h0);
    chk("rst_cmdcnt", {16'h0, cmd_count}, 32'h0);
    chk("rst_do", {31'h0, DO}, 32'h0);
    chk("rst_dbg", {24'h0, dbg_data}, 32'h0);
    rst = 1'b0;
    tick(4);

    // WREN then RDSR shows WEL
    cmd1(8'h06);
    rdsr_sb("rdsr_wel");
    chk("wel_status", {24'h0, status}, 32'h02);
    chk("cmdcnt_2", {16'h0, cmd_count}, exp_cmds);

    // page program with latency, then verify through the debug port
    cmd1(8'h06);
    pp(24'h000010, 2, 16'hA53C);
    chk("pp_wip", {24'h0, status}, 32'h01);
    wait_idle("pp_done");
    dbg_chk("dbg_010", 12'h010);
    dbg_chk("dbg_011", 12'h011);
    chk("pp_status", {24'h0, status}, 32'h00);

    // program only clears bits
    cmd1(8'h06);
    pp(24'h000010, 1, 16'h0F00);
    wait_idle("pp_and_done");
    dbg_chk("dbg_010_and", 12'h010);

    // PP without WREN is ignored but still counted
    pp(24'h000020, 1, 16'h0000);
    tick(4);
    dbg_chk("dbg_020_nowel", 12'h020);
    chk("cmdcnt_nowel", {16'h0, cmd_count}, exp_cmds);

    // page wrap and top-of-array byte
    cmd1(8'h06);
    pp(24'h0000FF, 2, 16'h1122);
    wait_idle("pp_wrap_done");
    cmd1(8'h06);
    pp(24'h000FFF, 1, 16'h5A00);
    wait_idle("pp_top_done");
    dbg_chk("dbg_0ff", 12'h0FF);
    dbg_chk("dbg_000", 12'h000);

    // READ wraps from the last byte to 0
    rd(24'h000FFF, 3);

    // sector erase of sector 0
    cmd1(8'h06);
    se(24'h000000);
    chk("se_wip", {24'h0, status}, 32'h01);
    n = 0;
    while (status[0] && n < 3000) begin
      tick(1);
      n++;
    end
    chk("se_len_ok", {31'h0, (n > 1000 && n < 1030)}, 32'h1);
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'hFF;
    dbg_chk("ers_000", 12'h000);
    dbg_chk("ers_010", 12'h010);
    dbg_chk("ers_0ff", 12'h0FF);
    dbg_chk("ers_3ff", 12'h3FF);
    dbg_chk("ers_fff_kept", 12'hFFF);
    chk("cmdcnt_mid", {16'h0, cmd_count}, exp_cmds);

    // aborted READ after 12 address bits: DO stays low, status untouched
    cmd1(8'h06);
    cs_lo();
    spi_bits(8, 32'h03, r);
    chk("abort_do_op", r, 32'h0);
    spi_bits(12, 32'hABC, r);
    chk("abort_do_addr", r, 32'h0);
    cs_hi();
    exp_cmds++;
    rdsr_sb("abort_rdsr");
    // WRDI with 9 bits must not clear WEL
    cs_lo();
    spi_bits(9, 32'h008, r);
    cs_hi();
    exp_cmds++;
    chk("wrdi9_status", {24'h0, status}, 32'h02);
    cmd1(8'h04);
    chk("wrdi_status", {24'h0, status}, 32'h00);
    chk("cmdcnt_abort", {16'h0, cmd_count}, exp_cmds);

    // reset in the middle of an erase
    cmd1(8'h06);
    se(24'h000400);
    tick(100);
    chk("se2_wip", {24'h0, status}, 32'h01);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_cmds = 0;
    m_wel = 1'b0;
    tick(1);
    chk("rst_mid_status", {24'h0, status}, 32'h00);
    chk("rst_mid_cmdcnt", {16'h0, cmd_count}, exp_cmds);
    tick(20);
    chk("rst_mid_stays", {24'h0, status}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
